// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan
//   Registered N-to-1 channel selector. In manual mode the channel is picked
//   by `sel`. In scan mode an internal sequencer steps through the channels
//   enabled in `chan_mask` and holds each one for dwell+1 cycles. A strobe
//   marks every new channel so downstream packers can capture samples.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   datain     packed channels, channel k = datain[k*WIDTH +: WIDTH]
//   mode       0 = manual, 1 = scan
//   sel        manual-mode channel select (out of range selects channel 0)
//   chan_mask  scan-mode per-channel enable
//   dwell      scan hold time, each channel is held dwell+1 cycles
//   start      pulse, begins a scan (scan mode, non-empty mask)
//   stop       pulse, ends a scan (wins over start)
//   dataout    registered selected channel data
//   chan       index of the channel on dataout
//   valid      strobe on the first cycle a new scanned channel appears
//   wrap       with valid, when that channel is the highest enabled one
//   busy       high while the scan sequencer is active
module mux_nto1_scan #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3,
   parameter int DWELL_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] datain,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS-1:0]       chan_mask,
   input  logic [DWELL_W-1:0]        dwell,
   input  logic                      start,
   input  logic                      stop,
   output logic [WIDTH-1:0]          dataout,
   output logic [SEL_W-1:0]          chan,
   output logic                      valid,
   output logic                      wrap,
   output logic                      busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   logic [0:0]         state_reg,   state_next;
   logic [DWELL_W-1:0] cnt_reg,     cnt_next;
   logic [WIDTH-1:0]   dataout_reg, dataout_next;
   logic [SEL_W-1:0]   chan_reg,    chan_next;
   logic               valid_reg,   valid_next;
   logic               wrap_reg,    wrap_next;
   logic               busy_reg,    busy_next;

   logic [WIDTH-1:0] ch_data [CHANNELS];

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
         assign ch_data[gi] = datain[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Channel index helpers: manual select (range-checked), lowest, highest
   // and next-above-current enabled channel.
   logic [SEL_W-1:0] manual_idx, low_idx, high_idx, next_idx, entry_idx;
   logic             any_set, next_found;

   always_comb begin
      manual_idx = '0;
      low_idx    = '0;
      high_idx   = '0;
      next_idx   = '0;
      any_set    = 1'b0;
      next_found = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) manual_idx = SEL_W'(k);
         if (chan_mask[k]) high_idx = SEL_W'(k);
      end
      // Descending walk so the lowest qualifying bit is the last one written.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (chan_mask[k]) begin
            low_idx = SEL_W'(k);
            any_set = 1'b1;
            if (SEL_W'(k) > chan_reg) begin
               next_idx   = SEL_W'(k);
               next_found = 1'b1;
            end
         end
      end
      // From IDLE a scan always starts at the lowest bit; in SCAN it wraps
      // there when nothing is enabled above the current channel.
      entry_idx = (state_reg == ST_SCAN && next_found) ? next_idx : low_idx;
   end

   logic [WIDTH-1:0] manual_data, cur_data, entry_data;

   always_comb begin
      manual_data = '0;
      cur_data    = '0;
      entry_data  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (manual_idx == SEL_W'(k)) manual_data = ch_data[k];
         if (chan_reg   == SEL_W'(k)) cur_data    = ch_data[k];
         if (entry_idx  == SEL_W'(k)) entry_data  = ch_data[k];
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      dataout_next = dataout_reg;
      chan_next    = chan_reg;
      valid_next   = 1'b0;
      wrap_next    = 1'b0;
      busy_next    = busy_reg;

      if (state_reg == ST_IDLE) begin
         if (mode && start && !stop && any_set) begin
            state_next   = ST_SCAN;
            chan_next    = entry_idx;
            dataout_next = entry_data;
            cnt_next     = dwell;
            valid_next   = 1'b1;
            wrap_next    = (entry_idx == high_idx);
            busy_next    = 1'b1;
         end else begin
            dataout_next = manual_data;
            chan_next    = manual_idx;
            busy_next    = 1'b0;
         end
      end else begin
         if (stop || !mode) begin
            // Leave the channel in place for this cycle; manual muxing
            // takes over on the next edge.
            state_next   = ST_IDLE;
            busy_next    = 1'b0;
            cnt_next     = '0;
            dataout_next = cur_data;
         end else if (cnt_reg == '0) begin
            if (!any_set) begin
               state_next   = ST_IDLE;
               busy_next    = 1'b0;
               cnt_next     = '0;
               dataout_next = cur_data;
            end else begin
               chan_next    = entry_idx;
               dataout_next = entry_data;
               cnt_next     = dwell;
               valid_next   = 1'b1;
               wrap_next    = (entry_idx == high_idx);
            end
         end else begin
            cnt_next     = cnt_reg - DWELL_W'(1);
            dataout_next = cur_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         dataout_reg <= '0;
         chan_reg    <= '0;
         valid_reg   <= 1'b0;
         wrap_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         dataout_reg <= dataout_next;
         chan_reg    <= chan_next;
         valid_reg   <= valid_next;
         wrap_reg    <= wrap_next;
         busy_reg    <= busy_next;
      end
   end

   assign dataout = dataout_reg;
   assign chan    = chan_reg;
   assign valid   = valid_reg;
   assign wrap    = wrap_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_mux_nto1_scan.sv
module tb_mux_nto1_scan;
   localparam int W  = 8;
   localparam int CH = 8;
   localparam int SW = 3;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic [CH*W-1:0]   datain;
   logic              mode;
   logic [SW-1:0]     sel;
   logic [CH-1:0]     chan_mask;
   logic [DW-1:0]     dwell;
   logic              start, stop;
   logic [W-1:0]      dataout;
   logic [SW-1:0]     chan;
   logic              valid, wrap, busy;

   logic [6*W-1:0]    datain6;
   logic [W-1:0]      dataout6;
   logic [SW-1:0]     chan6;
   logic              valid6, wrap6, busy6;
   assign datain6 = datain[6*W-1:0];

   mux_nto1_scan #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .datain(datain), .mode(mode), .sel(sel),
      .chan_mask(chan_mask), .dwell(dwell), .start(start), .stop(stop),
      .dataout(dataout), .chan(chan), .valid(valid), .wrap(wrap), .busy(busy));

   // Six-channel instance exercises the out-of-range select path.
   mux_nto1_scan #(.WIDTH(W), .CHANNELS(6), .SEL_W(SW), .DWELL_W(DW)) dut6 (
      .clk(clk), .reset_n(reset_n), .datain(datain6), .mode(1'b0), .sel(sel),
      .chan_mask(6'h3F), .dwell(16'd0), .start(1'b0), .stop(1'b0),
      .dataout(dataout6), .chan(chan6), .valid(valid6), .wrap(wrap6), .busy(busy6));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit       m_scan;
   int       m_chan, m_age, m_hold;
   logic [W-1:0] m_data;
   bit       m_valid, m_wrap, m_busy;
   int       cyc = 0;

   function automatic logic [W-1:0] ch_val(input int k);
      return datain[k*W +: W];
   endfunction

   function automatic int lowest(input logic [CH-1:0] m);
      for (int k = 0; k < CH; k++) if (m[k]) return k;
      return -1;
   endfunction

   function automatic int highest(input logic [CH-1:0] m);
      for (int k = CH - 1; k >= 0; k--) if (m[k]) return k;
      return -1;
   endfunction

   function automatic int next_after(input logic [CH-1:0] m, input int cur);
      for (int k = cur + 1; k < CH; k++) if (m[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_scan = 0; m_chan = 0; m_age = 0; m_hold = 1;
      m_data = '0; m_valid = 0; m_wrap = 0; m_busy = 0;
   endtask

   task automatic model_enter(input int k);
      m_scan  = 1;
      m_chan  = k;
      m_data  = ch_val(k);
      m_age   = 0;
      m_hold  = int'(dwell) + 1;
      m_valid = 1;
      m_wrap  = (k == highest(chan_mask));
      m_busy  = 1;
   endtask

   task automatic model_go_idle();
      m_scan = 0; m_busy = 0; m_valid = 0; m_wrap = 0;
      m_data = ch_val(m_chan);
   endtask

   task automatic model_step();
      int k;
      if (!m_scan) begin
         if (mode && start && !stop && chan_mask != 0) begin
            model_enter(lowest(chan_mask));
         end else begin
            k = (int'(sel) < CH) ? int'(sel) : 0;
            m_chan = k; m_data = ch_val(k);
            m_valid = 0; m_wrap = 0; m_busy = 0;
         end
      end else if (stop || !mode) begin
         model_go_idle();
      end else if (m_age + 1 == m_hold) begin
         if (chan_mask == 0) model_go_idle();
         else begin
            k = next_after(chan_mask, m_chan);
            if (k < 0) k = lowest(chan_mask);
            model_enter(k);
         end
      end else begin
         m_age++;
         m_data = ch_val(m_chan);
         m_valid = 0; m_wrap = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else begin
            cyc++;
            model_step();
         end
      end
   end

   // ---------------- per-cycle compare and valid capture ----------------
   bit cmp_en = 0;
   bit cap_en = 0;
   int cap_chan[$];
   int cap_wrap[$];
   int cap_cyc[$];

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("cmp_dataout", dataout, m_data);
         check("cmp_chan",    chan,    m_chan);
         check("cmp_valid",   valid,   m_valid);
         check("cmp_wrap",    wrap,    m_wrap);
         check("cmp_busy",    busy,    m_busy);
      end
      if (cap_en && valid === 1'b1) begin
         cap_chan.push_back(int'(chan));
         cap_wrap.push_back(int'(wrap));
         cap_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic clear_cap();
      cap_chan.delete(); cap_wrap.delete(); cap_cyc.delete();
   endtask

   // Checks a captured strobe sequence against literal chan/wrap tables.
   task automatic check_seq(input string tag, input int n, input int exp_ch[],
                            input int exp_wr[], input int spacing);
      check({tag, "_count"}, cap_chan.size(), n);
      for (int i = 0; i < n && i < cap_chan.size(); i++) begin
         check($sformatf("%s_chan[%0d]", tag, i), cap_chan[i], exp_ch[i]);
         check($sformatf("%s_wrap[%0d]", tag, i), cap_wrap[i], exp_wr[i]);
         if (i > 0) check($sformatf("%s_gap[%0d]", tag, i), cap_cyc[i] - cap_cyc[i-1], spacing);
         $display("tb: %s strobe %0d chan=%0d wrap=%0d cyc=%0d", tag, i, cap_chan[i], cap_wrap[i], cap_cyc[i]);
      end
   endtask

   // ---------------- directed stimulus ----------------
   logic [W-1:0] man_tab [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};

   initial begin
      reset_n = 1'b0;
      for (int k = 0; k < CH; k++) datain[k*W +: W] = 8'hA0 + W'(k);
      mode = 0; sel = '0; chan_mask = '0; dwell = '0; start = 0; stop = 0;
      repeat (3) @(negedge clk);
      check("rst_dataout", dataout, 0);
      check("rst_chan",    chan,    0);
      check("rst_valid",   valid,   0);
      check("rst_wrap",    wrap,    0);
      check("rst_busy",    busy,    0);
      reset_n = 1'b1;
      cmp_en  = 1;

      // Manual sweep, one cycle latency
      for (int s = 0; s < 8; s++) begin
         sel = SW'(s);
         @(negedge clk);
         check($sformatf("man_data[%0d]", s), dataout, man_tab[s]);
         check($sformatf("man_chan[%0d]", s), chan, s);
         check($sformatf("man_valid[%0d]", s), valid, 0);
         if (s < 6) check($sformatf("man6_data[%0d]", s), dataout6, man_tab[s]);
         else if (s == 7) begin
            check("man6_oob_data", dataout6, 8'hA0);
            check("man6_oob_chan", chan6, 0);
         end
         $display("tb: manual sel=%0d dataout=%0h chan=%0d", s, dataout, chan);
      end

      // Full scan, dwell 2
      mode = 1; chan_mask = 8'hFF; dwell = 16'd2;
      clear_cap(); cap_en = 1;
      pulse_start();
      repeat (25) @(negedge clk);
      check_seq("full", 9, '{0,1,2,3,4,5,6,7,0}, '{0,0,0,0,0,0,0,1,0}, 3);
      cap_en = 0;
      pulse_stop();
      @(negedge clk);

      // Stop during dwell of channel 3 (entered at the 9th edge after start)
      sel = 3'd6;
      pulse_start();
      repeat (9) @(negedge clk);
      check("stop_on_chan", chan, 3);
      pulse_stop();
      check("stop_busy",  busy,  0);
      check("stop_valid", valid, 0);
      @(negedge clk);
      check("stop_follow_data", dataout, 8'hA6);
      check("stop_follow_chan", chan, 6);
      $display("tb: stop during chan 3, then dataout=%0h", dataout);

      // start+stop together, and start with empty mask
      start = 1; stop = 1;
      @(negedge clk);
      start = 0; stop = 0;
      check("collide_busy", busy, 0);
      chan_mask = '0;
      pulse_start();
      check("nomask_busy", busy, 0);
      $display("tb: collision and empty-mask starts ignored, busy=%0d", busy);

      // Sparse mask, dwell 0
      chan_mask = 8'b1010_0100; dwell = 16'd0;
      clear_cap(); cap_en = 1;
      pulse_start();
      repeat (5) @(negedge clk);
      check_seq("sparse", 6, '{2,5,7,2,5,7}, '{0,0,1,0,0,1}, 1);
      cap_en = 0;
      pulse_stop();
      @(negedge clk);

      // Live data and mid-dwell mask change, dwell 5 (chan 4 entered at edge 24)
      chan_mask = 8'hFF; dwell = 16'd5;
      pulse_start();
      repeat (25) @(negedge clk);
      datain[4*W +: W] = 8'h5A;
      chan_mask = 8'hDF;
      @(negedge clk);
      check("live_data", dataout, 8'h5A);
      check("live_chan", chan, 4);
      repeat (4) @(negedge clk);
      check("skip_chan",  chan,  6);
      check("skip_valid", valid, 1);
      $display("tb: live data tracked, masked chan 5 skipped, now chan=%0d", chan);
      datain[4*W +: W] = 8'hA4;
      chan_mask = 8'hFF;
      mode = 0;                       // mode drop ends the scan
      @(negedge clk);
      check("modedrop_busy", busy, 0);
      @(negedge clk);
      mode = 1;

      // Asynchronous reset mid-scan
      dwell = 16'd2;
      pulse_start();
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_dataout", dataout, 0);
      check("arst_chan",    chan,    0);
      check("arst_valid",   valid,   0);
      check("arst_wrap",    wrap,    0);
      check("arst_busy",    busy,    0);
      $display("tb: async reset mid-scan cleared outputs");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Single enabled channel after reset, dwell 3
      chan_mask = 8'h01; dwell = 16'd3;
      clear_cap(); cap_en = 1;
      pulse_start();
      repeat (9) @(negedge clk);
      check_seq("single", 3, '{0,0,0}, '{1,1,1}, 4);
      cap_en = 0;
      pulse_stop();
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
